// File: rtl/alu_muldiv.sv
// Execute-stage integer ALU with a valid/ready handshake.
// RV32I base ops complete in one cycle; M-extension ops iterate at radix 2.
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            zero,
  output logic            last_bit,
  output logic            busy
);

  localparam int unsigned DW  = 2 * XLEN;
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DW-1:0]     mcand_q, mcand_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic              bsgn_q, bsgn_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;
  logic              last_q, last_d;

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;
  logic [2:0]        m_op;
  logic              a_sgn, b_sgn, sdiv;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [DW-1:0]     partial;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   quo_fin, rem_fin;

  // in_ready follows only state and out_ready, never in_valid or operands
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign alu_res   = res_q;
  assign zero      = zero_q;
  assign last_bit  = last_q;

  // Single-cycle base operations
  always_comb begin
    base_res = '0;
    shamt    = src2[SHW-1:0];
    case (alu_ctrl[3:0])
      4'b0000: base_res = src1 + src2;
      4'b0001: base_res = src1 - src2;
      4'b0010: base_res = src1 & src2;
      4'b0011: base_res = src1 | src2;
      4'b0100: base_res = src1 << shamt;
      4'b0101: base_res = XLEN'($signed(src1) < $signed(src2));
      4'b0110: base_res = src1 >> shamt;
      4'b0111: base_res = XLEN'(src1 < src2);
      4'b1000: base_res = src1 ^ src2;
      4'b1001: base_res = XLEN'($signed(src1) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // Operand preparation for the iterative unit
  always_comb begin
    m_op  = alu_ctrl[2:0];
    sdiv  = (m_op == 3'b100) || (m_op == 3'b110);
    a_sgn = src1[XLEN-1] && ((m_op == 3'b001) || (m_op == 3'b010) || sdiv);
    b_sgn = src2[XLEN-1] && ((m_op == 3'b001) || sdiv);
    abs_a = a_sgn ? -src1 : src1;
    abs_b = b_sgn ? -src2 : src2;
  end

  // Next-state, datapath step and result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    bsgn_d   = bsgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    res_d    = res_q;
    partial  = mplier_q[0] ? mcand_q : '0;
    r_sh     = {rem_q, quo_q[XLEN-1]};
    diff     = r_sh - {1'b0, dvsr_q};
    quo_fin  = '0;
    rem_fin  = '0;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (!op_q[2]) begin
            // Signed multiplier MSB carries negative weight
            if ((cnt_q == CW'(1)) && bsgn_q) acc_d = acc_q - partial;
            else                              acc_d = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end else if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = r_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CW'(1)) begin
            quo_fin = qneg_q ? -quo_d : quo_d;
            rem_fin = rneg_q ? -rem_d : rem_d;
            if (div0_q) begin
              quo_fin = '1;
              rem_fin = a_q;
            end else if (ovf_q) begin
              quo_fin = a_q;
              rem_fin = '0;
            end
            case (op_q)
              3'b000:  res_d = acc_d[XLEN-1:0];
              3'b001,
              3'b010,
              3'b011:  res_d = acc_d[DW-1:XLEN];
              3'b100,
              3'b101:  res_d = quo_fin;
              default: res_d = rem_fin;
            endcase
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase

      if (accept) begin
        if (!alu_ctrl[4]) begin
          res_d   = base_res;
          state_d = S_DONE;
        end else begin
          op_d     = m_op;
          cnt_d    = CW'(XLEN);
          mcand_d  = {{XLEN{a_sgn}}, src1};
          acc_d    = '0;
          mplier_d = src2;
          bsgn_d   = (m_op == 3'b001);
          quo_d    = abs_a;
          rem_d    = '0;
          dvsr_d   = abs_b;
          a_d      = src1;
          qneg_d   = (m_op == 3'b100) && (a_sgn ^ b_sgn);
          rneg_d   = (m_op == 3'b110) && a_sgn;
          div0_d   = (src2 == '0);
          ovf_d    = sdiv && (src1 == MOST_NEG) && (src2 == '1);
          state_d  = S_BUSY;
        end
      end
    end

    zero_d = (res_d == '0);
    last_d = res_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      bsgn_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      bsgn_q   <= bsgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN = 32).
module tb_alu_muldiv;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SLTU   = 5'b00111;
  localparam logic [4:0] OP_XOR    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_BAD    = 5'b01010;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b11111;

  logic            clk, rst, in_valid, in_ready, flush;
  logic            out_valid, out_ready, zero, last_bit, busy;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] src1, src2, alu_res;
  int              total = 0;
  int              bad   = 0;
  int              nv;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_res   (alu_res),
    .zero      (zero),
    .last_bit  (last_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, check latency, busy length and result, then drain
  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    int n;
    int nb;
    alu_ctrl = ctrl;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n  = 1;
    nb = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      step();
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(lat));
    chk({tag, "/busy_cycles"}, 32'(nb), (lat > 1) ? 32'(XLEN) : 32'd0);
    chk({tag, "/res"}, alu_res, exp);
    chk({tag, "/zero"}, 32'(zero), (exp == 32'd0) ? 32'd1 : 32'd0);
    chk({tag, "/last_bit"}, 32'(last_bit), 32'(exp[0]));
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    alu_ctrl  = '0;
    src1      = '0;
    src2      = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/alu_res", alu_res, 32'd0);
    chk("reset/zero", 32'(zero), 32'd1);
    chk("reset/last_bit", 32'(last_bit), 32'd0);

    // ADD then SRA back-to-back
    alu_ctrl = OP_ADD; src1 = 32'd5; src2 = 32'hFFFF_FFFB; in_valid = 1'b1;
    step();
    chk("add/out_valid", 32'(out_valid), 32'd1);
    chk("add/res", alu_res, 32'd0);
    chk("add/zero", 32'(zero), 32'd1);
    alu_ctrl = OP_SRA; src1 = 32'h8000_0000; src2 = 32'd31;
    chk("b2b/in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("sra/out_valid", 32'(out_valid), 32'd1);
    chk("sra/res", alu_res, 32'hFFFF_FFFF);
    chk("sra/zero", 32'(zero), 32'd0);
    chk("sra/last_bit", 32'(last_bit), 32'd1);
    step();
    chk("drain/out_valid", 32'(out_valid), 32'd0);

    // Remaining base ops
    run_op("sub",   OP_SUB,  32'd3,          32'd5,          1, 32'hFFFF_FFFE);
    run_op("and",   OP_AND,  32'hF0F0_FF00,  32'h0FF0_F0F0,  1, 32'h00F0_F000);
    run_op("or",    OP_OR,   32'hF000_0001,  32'h0000_0F00,  1, 32'hF000_0F01);
    run_op("xor",   OP_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  1, 32'h5555_5555);
    run_op("sll",   OP_SLL,  32'h0000_0003,  32'h0000_0024,  1, 32'h0000_0030);
    run_op("srl",   OP_SRL,  32'h8000_0000,  32'd31,         1, 32'd1);
    run_op("slt",   OP_SLT,  32'hFFFF_FFFF,  32'd1,          1, 32'd1);
    run_op("sltu",  OP_SLTU, 32'hFFFF_FFFF,  32'd1,          1, 32'd0);
    run_op("illeg", OP_BAD,  32'd7,          32'd9,          1, 32'd0);

    // Multiplies
    run_op("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);

    // Divides and special cases
    run_op("div",      OP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD);
    run_op("rem",      OP_REM,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF);
    run_op("divu",     OP_DIVU, 32'd100,       32'd7,         33, 32'd14);
    run_op("remu",     OP_REMU, 32'd100,       32'd7,         33, 32'd2);
    run_op("div0",     OP_DIV,  32'd123,       32'd0,         33, 32'hFFFF_FFFF);
    run_op("remu0",    OP_REMU, 32'd123,       32'd0,         33, 32'd123);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

    // Backpressure on a completed MUL with a pending ADD
    out_ready = 1'b0;
    alu_ctrl = OP_MUL; src1 = 32'd3; src2 = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    nv = 1;
    while (!out_valid && nv < 100) begin
      step();
      nv++;
    end
    chk("bp/latency", 32'(nv), 32'd33);
    alu_ctrl = OP_ADD; src1 = 32'd2; src2 = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp/res_hold", alu_res, 32'd15);
      chk("bp/in_ready", 32'(in_ready), 32'd0);
      chk("bp/out_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp/release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp/pending_valid", 32'(out_valid), 32'd1);
    chk("bp/pending_res", alu_res, 32'd5);
    step();

    // Flush in BUSY cycle 10
    alu_ctrl = OP_MUL; src1 = 32'd7; src2 = 32'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("flush/busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush/busy", 32'(busy), 32'd0);
    chk("flush/out_valid", 32'(out_valid), 32'd0);
    chk("flush/in_ready", 32'(in_ready), 32'd1);
    nv = 0;
    repeat (40) begin
      if (out_valid) nv++;
      step();
    end
    chk("flush/no_valid", 32'(nv), 32'd0);
    run_op("flush_add", OP_ADD, 32'd1, 32'd1, 1, 32'd2);

    // Same abort through rst
    alu_ctrl = OP_MUL; src1 = 32'd7; src2 = 32'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("rst/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    chk("rst/alu_res", alu_res, 32'd0);
    chk("rst/zero", 32'(zero), 32'd1);
    chk("rst/last_bit", 32'(last_bit), 32'd0);
    nv = 0;
    repeat (40) begin
      if (out_valid) nv++;
      step();
    end
    chk("rst/no_valid", 32'(nv), 32'd0);
    run_op("rst_add", OP_ADD, 32'd1, 32'd1, 1, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
